hilo_div_unit: RTL and testbench

Iterative 32-bit divider executing DIV/DIVU in the execute stage. It takes the divide request produced by the main decoder's HI/LO write path, stalls the pipeline while it runs, and returns {HI, LO} = {remainder, quotient} for the HI/LO register write. The core is a radix-2 restoring algorithm driven by a small state machine with a start/ready handshake and an annul input for flushes.

---
 rtl/hilo_div_unit.sv | 126 ++++++++++++
 tb/tb_hilo_div_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; returns {HI, LO} = {remainder, quotient}.
// Optional macro DIV_ZERO_SHORTCUT_EN: zero divisor short-circuits through BYZERO with result 0.
module hilo_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic        annul,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    output logic [63:0] result,
    output logic        ready,
    output logic        stall
);

    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] abs_dividend, abs_divisor;
    logic [64:0] shifted, step;
    logic [33:0] trial;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        abs_dividend = (signed_div && opdata1[31]) ? (~opdata1 + 32'd1) : opdata1;
        abs_divisor  = (signed_div && opdata2[31]) ? (~opdata2 + 32'd1) : opdata2;

        // Extra top bit of trial is the borrow of the 33-bit subtraction.
        shifted = work_q << 1;
        trial   = {1'b0, shifted[64:32]} - {2'b00, divisor_q};
        step    = trial[33] ? shifted : {trial[32:0], shifted[31:0] | 32'd1};

        quo_fix = neg_quo_q ? (~step[31:0] + 32'd1)  : step[31:0];
        rem_fix = neg_rem_q ? (~step[63:32] + 32'd1) : step[63:32];

        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !annul) begin
                    work_d    = {33'd0, abs_dividend};
                    divisor_d = abs_divisor;
                    neg_quo_d = signed_div & (opdata1[31] ^ opdata2[31]);
                    neg_rem_d = signed_div & opdata1[31];
                    cnt_d     = 6'd0;
`ifdef DIV_ZERO_SHORTCUT_EN
                    state_d   = (opdata2 == 32'd0) ? S_BYZERO : S_ON;
`else
                    state_d   = S_ON;
`endif
                end
            end
            S_BYZERO: begin
`ifdef DIV_ZERO_SHORTCUT_EN
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_END;
                    result_d = 64'd0;
                    ready_d  = 1'b1;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_ON: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    work_d = step;
                    cnt_d  = cnt_q + 6'd1;
                    // Last step: commit the sign-fixed result so ready lines up with END.
                    if (cnt_q == 6'd31) begin
                        state_d  = S_END;
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;
    assign stall  = (state_q == S_ON) || (state_q == S_BYZERO) ||
                    ((state_q == S_IDLE) && start && !annul);

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: transaction-level model plus directed vectors.
// Honours DIV_ZERO_SHORTCUT_EN the same way the design does.
module tb_hilo_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] opdata1 = 32'd0;
    logic [31:0] opdata2 = 32'd0;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int nchk = 0;
    int nfail = 0;

    hilo_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
        .opdata1(opdata1), .opdata2(opdata2), .result(result), .ready(ready), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result from plain arithmetic (C-style truncating division).
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
`ifdef DIV_ZERO_SHORTCUT_EN
            return 64'd0;
`else
            return {a, (sg && a[31]) ? 32'd1 : 32'hFFFF_FFFF};
`endif
        end
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_ZERO_SHORTCUT_EN
        if (b == 32'd0) return 2;
`endif
        return 33;
    endfunction

    // Transaction model: countdown of edges until the result is committed.
    int          m_cd = 0;
    logic        m_ready = 1'b0;
    logic [63:0] m_res = 64'd0;
    logic [63:0] m_pend = 64'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cd    <= 0;
            m_ready <= 1'b0;
            m_res   <= 64'd0;
        end else begin
            m_ready <= 1'b0;
            if (m_cd > 0) begin
                if (annul) begin
                    m_cd <= 0;
                end else begin
                    m_cd <= m_cd - 1;
                    if (m_cd == 1) begin
                        m_ready <= 1'b1;
                        m_res   <= m_pend;
                    end
                end
            end else if (!m_ready && start && !annul) begin
                m_cd   <= ref_lat(opdata2) - 1;
                m_pend <= ref_div(opdata1, opdata2, signed_div);
            end
        end
    end

    always @(negedge clk) begin
        logic exp_stall;
        exp_stall = (m_cd > 0) || (m_cd == 0 && !m_ready && !rst && start && !annul);
        chk("cyc_ready", {63'd0, ready}, {63'd0, m_ready});
        chk("cyc_result", result, m_res);
        chk("cyc_stall", {63'd0, stall}, {63'd0, exp_stall});
    end

    task automatic do_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input logic [63:0] exp, input int lat);
        int n;
        bit seen;
        opdata1 = a; opdata2 = b; signed_div = sg; start = 1'b1;
        #1;
        chk({nm, "_stall0"}, {63'd0, stall}, 64'd1);
        n = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (ready) seen = 1;
            else if (!stall) begin
                chk({nm, "_stall_busy"}, 64'd0, 64'd1);
            end
        end
        start = 1'b0;
        chk({nm, "_latency"}, 64'(n), 64'(lat));
        chk({nm, "_result"}, result, exp);
        chk({nm, "_stall_end"}, {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        chk({nm, "_ready_pulse"}, {63'd0, ready}, 64'd0);
        chk({nm, "_model"}, ref_div(a, b, sg), exp);
    endtask

    initial begin
        bit any_ready;
        #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_result", result, 64'd0);
        chk("rst_ready", {63'd0, ready}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_div("divu_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
        do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        do_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
        do_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33);
        do_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'h0, 32'hFFFF_FFFF}, 33);
        do_div("div_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'd14}, 33);
`ifdef DIV_ZERO_SHORTCUT_EN
        do_div("divu_5_0", 32'd5, 32'd0, 1'b0, 64'd0, 2);
        do_div("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 64'd0, 2);
`else
        do_div("divu_5_0", 32'd5, 32'd0, 1'b0, {32'd5, 32'hFFFF_FFFF}, 33);
        do_div("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, {32'hFFFF_FFFB, 32'd1}, 33);
`endif
        do_div("divu_3_10", 32'd3, 32'd10, 1'b0, {32'd3, 32'd0}, 33);

        // Annul during ON: no ready, prior result retained.
        opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        chk("annul_stall", {63'd0, stall}, 64'd0);
        chk("annul_ready", {63'd0, ready}, 64'd0);
        chk("annul_result", result, {32'd3, 32'd0});
        any_ready = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) any_ready = 1;
        end
        chk("annul_no_ready", {63'd0, any_ready}, 64'd0);

        // Asynchronous reset mid-ON.
        opdata1 = 32'd50; opdata2 = 32'd5; start = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        #2 rst = 1'b1; start = 1'b0;
        #1;
        chk("arst_result", result, 64'd0);
        chk("arst_ready", {63'd0, ready}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_div("divu_9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
